dff_pipeline: RTL and testbench

//  Parametrised successor to the single-bit master-slave D flip-flop.

---
 rtl/dff_pipeline.sv | 112 +++++++++++
 tb/tb_dff_pipeline.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// dff_pipeline: elastic register slice / retiming pipe.
//   DEPTH stages of WIDTH-bit registers, each with a valid bit, under
//   valid/ready flow control. Bubbles collapse as soon as a downstream
//   stage stalls. Exposes true and complemented output words.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, empties the pipe and zeroes data
//   clr        synchronous flush (present only with DFF_PIPE_CLR_EN)
//   in_valid   producer offers in_data
//   in_ready   pipe accepts in_data this cycle (never depends on in_valid)
//   in_data    input word
//   out_valid  last stage holds a word
//   out_ready  consumer takes out_data this cycle
//   out_data   last-stage word
//   out_data_n bitwise complement of out_data
//   occ        registered count of valid stages, 0..DEPTH
//
// Build option:
//   DFF_PIPE_CLR_EN  adds the clr port; clr overrides any same-cycle transfer.
module dff_pipeline #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef DFF_PIPE_CLR_EN
    input  logic                       clr,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH-1:0]           out_data_n,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            adv;
    logic                        in_xfer;
    logic                        out_xfer;
    logic                        flush;
    logic [OCC_W-1:0]            occ_next;

`ifdef DFF_PIPE_CLR_EN
    assign flush = clr;
`else
    assign flush = 1'b0;
`endif

    // Stage i may load when it is empty or the stage after it advances.
    // Walked from the output end with a running term so each adv bit is
    // written exactly once.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            chain              = !v[DEPTH-1-i] || chain;
            adv[DEPTH-1-i]     = chain;
        end
    end

    assign in_ready   = adv[0];
    assign out_valid  = v[DEPTH-1];
    assign out_data   = data[DEPTH-1];
    assign out_data_n = ~data[DEPTH-1];

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        occ_next = occ;
        if (in_xfer && !out_xfer)
            occ_next = occ + 1'b1;
        else if (!in_xfer && out_xfer)
            occ_next = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= '0;
            data <= '0;
            occ  <= '0;
        end else if (flush) begin
            v    <= '0;
            data <= '0;
            occ  <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid)
                    data[0] <= in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    // Invalid words are not copied; stale data stays put.
                    if (v[i-1])
                        data[i] <= data[i-1];
                end
            end
            occ <= occ_next;
        end
    end

endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: scoreboard bench for dff_pipeline (WIDTH=8, DEPTH=4).
//   Accepted words are queued; words leaving the pipe are popped and compared.
module tb_dff_pipeline;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [W-1:0] out_data_n;
    logic [2:0]   occ;

    always #5 clk = ~clk;

    dff_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DFF_PIPE_CLR_EN
        .clr        (clr),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_data_n (out_data_n),
        .occ        (occ)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] q[$];
    int         stepno = 0;
    int         acc_step = 0;
    int         first_pop = -1;
    int         last_pop_step = 0;
    int         pops = 0;
    int         accs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at posedge+1, sample at the falling edge, then advance.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic c);
        logic [7:0] e;
        logic [7:0] en;
        logic       acc;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        #4;
        stepno++;
        check("occ", 32'(occ), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(!(q.size() == D && !ordy)));
        acc = iv && in_ready;
        if (c) begin
            q.delete();
        end else begin
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e  = q.pop_front();
                    en = ~e;
                    check("out_data", 32'(out_data), 32'(e));
                    check("out_data_n", 32'(out_data_n), 32'(en));
                    pops++;
                    if (first_pop < 0)
                        first_pop = stepno;
                    last_pop_step = stepno;
                end
            end
            if (acc) begin
                q.push_back(d);
                accs++;
                acc_step = stepno;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a5_step;

        // Reset state, no clock edge yet.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_data_n", 32'(out_data_n), 32'hFF);
        check("rst_occ", 32'(occ), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with out_ready held high.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        a5_step = acc_step;
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b1, 8'h0F, 1'b1, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_latency", 32'(first_pop - a5_step), 32'(D));
        check("stream_rate", 32'(last_pop_step - first_pop), 32'd2);
        check("stream_pops", 32'(pops), 32'd3);

        // Back-pressure: six offers into a stalled pipe.
        accs = 0;
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("bp_accepts", 32'(accs), 32'd4);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold", 32'(out_data), 32'h40);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_hold2", 32'(out_data), 32'h40);
        check("bp_occ", 32'(occ), 32'd4);

        // Full pipe with simultaneous in and out.
        pops = 0;
        accs = 0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
        check("full_occ", 32'(occ), 32'd4);
        check("full_pops", 32'(pops), 32'd3);
        check("full_accs", 32'(accs), 32'd3);

        repeat (D + 3) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained", 32'(q.size()), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Bubble collapse under stall.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_occ", 32'(occ), 32'd2);
        check("bubble_head", 32'(out_data), 32'h11);
        pops = 0;
        first_pop = -1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("bubble_pops", 32'(pops), 32'd2);
        check("bubble_b2b", 32'(last_pop_step - first_pop), 32'd1);

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h9A, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'h00);
        check("arst_out_data_n", 32'(out_data_n), 32'hFF);
        check("arst_occ", 32'(occ), 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        pops = 0;
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_pops", 32'(pops), 32'd1);

`ifdef DFF_PIPE_CLR_EN
        // Flush with a same-cycle input word that must be dropped.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check("clr_pre_occ", 32'(occ), 32'd3);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("clr_occ", 32'(occ), 32'd0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        pops = 0;
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("clr_no_emerge", 32'(pops), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
